// File: rtl/fp21_mult_prep_if.sv
// Operand/side-band bundle between the FP21 multiplier front-end and its neighbours.
interface fp21_mult_prep_if;
   logic        in_valid;
   logic [20:0] in_a;
   logic [20:0] in_b;
   logic        clr_cnt;
   logic        sign_a;
   logic        sign_b;
   logic [12:0] frac_a;
   logic [12:0] frac_b;
   logic [7:0]  exp_a;
   logic [7:0]  exp_b;
   logic        sb_valid;
   logic        sb_special;
   logic [20:0] sb_word;
   logic [15:0] special_cnt;

   modport master (
      output in_valid, in_a, in_b, clr_cnt,
      input  sign_a, sign_b, frac_a, frac_b, exp_a, exp_b,
      input  sb_valid, sb_special, sb_word, special_cnt
   );

   modport slave (
      input  in_valid, in_a, in_b, clr_cnt,
      output sign_a, sign_b, frac_a, frac_b, exp_a, exp_b,
      output sb_valid, sb_special, sb_word, special_cnt
   );
endinterface

// File: rtl/fp21_mult_prep.sv
// FP21 multiplier front-end: unpacks operands, classifies specials, pre-biases the
// exponent and carries override results in a side-band matched to the core latency.
module fp21_mult_prep #(
   parameter int unsigned MULT_LAT = 6
) (
   input  logic              clk,
   input  logic              rst,
   fp21_mult_prep_if.slave   bus
);
   localparam int unsigned SB_DEPTH = 1 + MULT_LAT;

   typedef enum logic [1:0] {CLS_NORMAL, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

   function automatic cls_e classify(input logic [7:0] e, input logic [11:0] f);
      if (e == '0)       return CLS_ZERO;
      else if (e == '1)  return (f == '0) ? CLS_INF : CLS_NAN;
      else               return CLS_NORMAL;
   endfunction

   cls_e               cls_a, cls_b;
   logic               rs;
   logic signed [9:0]  exp_sum;
   logic               special;
   logic [20:0]        word;
   logic               accept_special;

   logic               sign_a_d, sign_a_q, sign_b_d, sign_b_q;
   logic [12:0]        frac_a_d, frac_a_q, frac_b_d, frac_b_q;
   logic [7:0]         exp_a_d, exp_a_q, exp_b_d, exp_b_q;
   logic [SB_DEPTH-1:0]         sb_valid_d, sb_valid_q;
   logic [SB_DEPTH-1:0]         sb_special_d, sb_special_q;
   logic [SB_DEPTH-1:0][20:0]   sb_word_d, sb_word_q;
   logic [15:0]        cnt_d, cnt_q;

   always_comb begin
      cls_a   = classify(bus.in_a[19:12], bus.in_a[11:0]);
      cls_b   = classify(bus.in_b[19:12], bus.in_b[11:0]);
      rs      = bus.in_a[20] ^ bus.in_b[20];
      exp_sum = $signed({2'b00, bus.in_a[19:12]} + {2'b00, bus.in_b[19:12]} - 10'd127);

      special = 1'b0;
      word    = '0;
      if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
          (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
          (cls_b == CLS_INF && cls_a == CLS_ZERO)) begin
         special = 1'b1;
         word    = 21'h0FF800;
      end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
         special = 1'b1;
         word    = {rs, 8'hFF, 12'h000};
      end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
         special = 1'b1;
         word    = {rs, 20'h0};
      end else if (exp_sum >= 10'sd255) begin
         special = 1'b1;
         word    = {rs, 8'hFF, 12'h000};
      end else if (exp_sum <= 10'sd0) begin
         special = 1'b1;
         word    = {rs, 20'h0};
      end

      accept_special = bus.in_valid & special;

      sign_a_d = 1'b0;
      sign_b_d = 1'b0;
      frac_a_d = '0;
      frac_b_d = '0;
      exp_a_d  = '0;
      exp_b_d  = '0;
      // Whole biased result exponent goes on exp_a so the core's raw add is already correct.
      if (bus.in_valid && !special) begin
         sign_a_d = bus.in_a[20];
         sign_b_d = bus.in_b[20];
         frac_a_d = {1'b1, bus.in_a[11:0]};
         frac_b_d = {1'b1, bus.in_b[11:0]};
         exp_a_d  = exp_sum[7:0];
      end

      sb_valid_d   = {sb_valid_q[SB_DEPTH-2:0], bus.in_valid};
      sb_special_d = {sb_special_q[SB_DEPTH-2:0], accept_special};
      sb_word_d    = {sb_word_q[SB_DEPTH-2:0], (accept_special ? word : 21'h0)};

      cnt_d = cnt_q;
      if (bus.clr_cnt)
         cnt_d = '0;
      else if (accept_special && cnt_q != '1)
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign_a_q     <= 1'b0;
         sign_b_q     <= 1'b0;
         frac_a_q     <= '0;
         frac_b_q     <= '0;
         exp_a_q      <= '0;
         exp_b_q      <= '0;
         sb_valid_q   <= '0;
         sb_special_q <= '0;
         sb_word_q    <= '0;
         cnt_q        <= '0;
      end else begin
         sign_a_q     <= sign_a_d;
         sign_b_q     <= sign_b_d;
         frac_a_q     <= frac_a_d;
         frac_b_q     <= frac_b_d;
         exp_a_q      <= exp_a_d;
         exp_b_q      <= exp_b_d;
         sb_valid_q   <= sb_valid_d;
         sb_special_q <= sb_special_d;
         sb_word_q    <= sb_word_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.sign_a      = sign_a_q;
   assign bus.sign_b      = sign_b_q;
   assign bus.frac_a      = frac_a_q;
   assign bus.frac_b      = frac_b_q;
   assign bus.exp_a       = exp_a_q;
   assign bus.exp_b       = exp_b_q;
   assign bus.sb_valid    = sb_valid_q[SB_DEPTH-1];
   assign bus.sb_special  = sb_special_q[SB_DEPTH-1];
   assign bus.sb_word     = sb_word_q[SB_DEPTH-1];
   assign bus.special_cnt = cnt_q;
endmodule
